if_fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer feeding the instruction queue. Holds the fetch pc, issues one

---
 rtl/if_fetch_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: holds the fetch pc, issues one word-fetch at a time and pushes words into the IQ.
// Optional direct-mapped instruction cache enabled by defining ICACHE_EN.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int unsigned ICACHE_IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clr,
    input  logic [31:0] clr_pc,
    input  logic        IQ_full,
    output logic        IF_S,
    output logic [31:0] IF_Inst,
    output logic [31:0] IF_pc,
    output logic        MC_req,
    output logic [31:0] MC_addr,
    input  logic        MC_Success,
    input  logic [31:0] MC_Inst
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              if_s_d;
    logic [XLEN-1:0]   if_inst_d, if_pc_d;
    logic              mc_req_d;
    logic [XLEN-1:0]   mc_addr_d;

    // The index/tag split must leave at least one tag bit and one index bit.
    if (ICACHE_IDX_W == 0 || ICACHE_IDX_W > 29) begin : g_bad_idx_w
        $error("ICACHE_IDX_W out of range");
    end

`ifdef ICACHE_EN
    localparam int unsigned ENTRIES = 32'(1) << ICACHE_IDX_W;
    localparam int unsigned TAG_W   = XLEN - ICACHE_IDX_W - 2;

    logic [ENTRIES-1:0]      c_valid;
    logic [TAG_W-1:0]        c_tag  [ENTRIES];
    logic [XLEN-1:0]         c_data [ENTRIES];
    logic [ICACHE_IDX_W-1:0] c_idx;
    logic [TAG_W-1:0]        c_tag_pc;
    logic                    c_hit;
    logic                    c_we;
    logic                    hit_gap_q, hit_gap_d;

    assign c_idx    = pc_q[ICACHE_IDX_W+1:2];
    assign c_tag_pc = pc_q[XLEN-1:ICACHE_IDX_W+2];
    assign c_hit    = c_valid[c_idx] && (c_tag[c_idx] == c_tag_pc);

    // Valid bits survive clr; only rst invalidates the cache.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_valid   <= '0;
            hit_gap_q <= 1'b0;
        end else if (rdy) begin
            hit_gap_q <= hit_gap_d;
            if (c_we) begin
                c_valid[c_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && c_we) begin
            c_tag[c_idx]  <= c_tag_pc;
            c_data[c_idx] <= MC_Inst;
        end
    end
`endif

    // State and output registers; rdy=0 freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            IF_S    <= 1'b0;
            IF_Inst <= '0;
            IF_pc   <= '0;
            MC_req  <= 1'b0;
            MC_addr <= '0;
        end else if (rdy) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            IF_S    <= if_s_d;
            IF_Inst <= if_inst_d;
            IF_pc   <= if_pc_d;
            MC_req  <= mc_req_d;
            MC_addr <= mc_addr_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        if_s_d    = 1'b0;
        if_inst_d = IF_Inst;
        if_pc_d   = IF_pc;
        mc_req_d  = MC_req;
        mc_addr_d = MC_addr;
`ifdef ICACHE_EN
        c_we      = 1'b0;
        hit_gap_d = 1'b0;
`endif
        if (clr) begin
            pc_d    = clr_pc;
            state_d = IDLE;
            if (state_q == WAIT || state_q == DROP) begin
                if (MC_Success) begin
                    mc_req_d = 1'b0;
                end else begin
                    state_d = DROP;
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
`ifdef ICACHE_EN
                    if (!IQ_full && !hit_gap_q) begin
                        if (c_hit) begin
                            if_s_d    = 1'b1;
                            if_inst_d = c_data[c_idx];
                            if_pc_d   = pc_q;
                            pc_d      = pc_q + XLEN'(4);
                            hit_gap_d = 1'b1;
                        end else begin
                            mc_req_d  = 1'b1;
                            mc_addr_d = pc_q;
                            state_d   = WAIT;
                        end
                    end
`else
                    if (!IQ_full) begin
                        mc_req_d  = 1'b1;
                        mc_addr_d = pc_q;
                        state_d   = WAIT;
                    end
`endif
                end
                WAIT: begin
                    if (MC_Success) begin
                        mc_req_d  = 1'b0;
                        if_inst_d = MC_Inst;
                        if_pc_d   = pc_q;
`ifdef ICACHE_EN
                        c_we      = 1'b1;
`endif
                        if (!IQ_full) begin
                            if_s_d  = 1'b1;
                            pc_d    = pc_q + XLEN'(4);
                            state_d = IDLE;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!IQ_full) begin
                        if_s_d  = 1'b1;
                        pc_d    = pc_q + XLEN'(4);
                        state_d = IDLE;
                    end
                end
                DROP: begin
                    if (MC_Success) begin
                        mc_req_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: a memory-controller model feeds responses, expected IQ pushes are queued
// when responses are driven and popped when IF_S fires. Define ICACHE_EN to also run the cache pass.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        clr = 1'b0;
    logic [31:0] clr_pc = '0;
    logic        IQ_full = 1'b0;
    logic        IF_S;
    logic [31:0] IF_Inst;
    logic [31:0] IF_pc;
    logic        MC_req;
    logic [31:0] MC_addr;
    logic        MC_Success = 1'b0;
    logic [31:0] MC_Inst = '0;

    if_fetch_ctrl #(.RESET_PC(32'h0), .ICACHE_IDX_W(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .clr_pc(clr_pc), .IQ_full(IQ_full),
        .IF_S(IF_S), .IF_Inst(IF_Inst), .IF_pc(IF_pc), .MC_req(MC_req), .MC_addr(MC_addr),
        .MC_Success(MC_Success), .MC_Inst(MC_Inst)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] addr_q[$];

    bit          mc_busy = 0;
    bit          mc_stale = 0;
    int          mc_cnt = 0;
    logic [31:0] mc_addr_l = '0;
    bit          pend_valid = 0;
    bit          pend_stale = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] pend_word = '0;
    bit          req_seen = 0;
    bit          prev_if_s = 0;
    bit          word_mode = 0;
    int          push_count = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] mc_word(input logic [31:0] a);
        return word_mode ? (a ^ 32'hC0DE_0013) : 32'h0000_0013;
    endfunction

    // One cycle: wait for the falling edge, score outputs, advance the memory model.
    task automatic tick();
        logic full_e, clr_e;
        logic [63:0] e;
        full_e = IQ_full;
        clr_e  = clr;
        @(negedge clk);
        clr        = 1'b0;
        MC_Success = 1'b0;
        req_seen   = 0;
        if (pend_valid) begin
            if (!pend_stale && !clr_e) exp_q.push_back({pend_addr, pend_word});
            pend_valid = 0;
        end
        if (!rst) begin
            if (IF_S) begin
                push_count++;
                check_eq("push_while_full", 32'(full_e), 32'd0);
                check_eq("b2b_push", 32'(prev_if_s), 32'd0);
                check_eq("push_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("IF_pc", IF_pc, e[63:32]);
                    check_eq("IF_Inst", IF_Inst, e[31:0]);
                end
            end
            prev_if_s = IF_S;
            if (MC_req && !mc_busy) begin
                req_seen = 1;
                check_eq("req_expected", 32'(addr_q.size() != 0), 32'd1);
                if (addr_q.size() != 0) check_eq("MC_addr", MC_addr, addr_q.pop_front());
                mc_busy   = 1;
                mc_stale  = 0;
                mc_cnt    = 3;
                mc_addr_l = MC_addr;
            end else if (mc_busy && rdy) begin
                mc_cnt--;
                if (mc_cnt == 0) begin
                    MC_Success = 1'b1;
                    MC_Inst    = mc_word(mc_addr_l);
                    pend_valid = 1;
                    pend_stale = mc_stale;
                    pend_addr  = mc_addr_l;
                    pend_word  = mc_word(mc_addr_l);
                    mc_busy    = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr = 1'b0;
        MC_Success = 1'b0;
        exp_q.delete();
        addr_q.delete();
        mc_busy = 0;
        pend_valid = 0;
        prev_if_s = 0;
        tick();
        check_eq("rst_IF_S", 32'(IF_S), 32'd0);
        check_eq("rst_MC_req", 32'(MC_req), 32'd0);
        check_eq("rst_MC_addr", MC_addr, 32'd0);
        check_eq("rst_IF_pc", IF_pc, 32'd0);
        check_eq("rst_IF_Inst", IF_Inst, 32'd0);
        tick();
        rst = 1'b0;
    endtask

    task automatic do_clr(input logic [31:0] pc);
        clr    = 1'b1;
        clr_pc = pc;
        if (mc_busy) mc_stale = 1;
    endtask

    task automatic wait_pushes(input int n);
        int target;
        target = push_count + n;
        for (int i = 0; i < 200 && push_count < target; i++) tick();
        check_eq("push_count", 32'(push_count), 32'(target));
    endtask

    task automatic wait_addr(input logic [31:0] a);
        bit seen;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (req_seen && mc_addr_l == a) seen = 1;
        end
        check_eq("req_wait", 32'(seen), 32'd1);
    endtask

    initial begin
        // Reset and steady-state fetch of 32'h13 words.
        IQ_full = 1'b0;
        do_reset();
        addr_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        wait_pushes(3);

        // IQ full when the response for 0x10 arrives: hold, then a single push.
        wait_addr(32'h10);
        IQ_full = 1'b1;
        repeat (4) tick();
        repeat (5) begin
            tick();
            check_eq("hold_no_push", 32'(IF_S), 32'd0);
        end
        IQ_full = 1'b0;
        addr_q.push_back(32'h14);
        wait_pushes(1);
        wait_addr(32'h14);

        // Reset mid-request, then redirect while waiting on 0x8.
        word_mode = 1;
        IQ_full = 1'b1;
        do_reset();
        tick();
        check_eq("full_no_req", 32'(MC_req), 32'd0);
        do_clr(32'h8);
        tick();
        IQ_full = 1'b0;
        addr_q.push_back(32'h8);
        wait_addr(32'h8);
        do_clr(32'h200);
        addr_q.push_back(32'h200);
        addr_q.push_back(32'h204);
        for (int i = 0; i < 10 && mc_busy; i++) begin
            tick();
            if (mc_busy || MC_Success) check_eq("drop_req_held", 32'(MC_req), 32'd1);
        end
        wait_pushes(1);

        // clr coincident with MC_Success, then two redirects while dropping.
        for (int i = 0; i < 50 && !(MC_Success && mc_addr_l == 32'h204); i++) tick();
        check_eq("succ_204", 32'(MC_Success), 32'd1);
        do_clr(32'h400);
        addr_q.push_back(32'h400);
        tick();
        check_eq("clr_succ_req_low", 32'(MC_req), 32'd0);
        check_eq("clr_succ_no_push", 32'(IF_S), 32'd0);
        wait_addr(32'h400);
        do_clr(32'h100);
        tick();
        do_clr(32'h300);
        addr_q.push_back(32'h300);
        addr_q.push_back(32'h304);
        wait_pushes(1);

        // rdy low for four cycles mid-request.
        wait_addr(32'h304);
        rdy = 1'b0;
        repeat (4) begin
            tick();
            check_eq("frz_MC_req", 32'(MC_req), 32'd1);
            check_eq("frz_MC_addr", MC_addr, 32'h304);
            check_eq("frz_IF_S", 32'(IF_S), 32'd0);
        end
        rdy = 1'b1;
        wait_pushes(1);
        IQ_full = 1'b1;
        tick();
        check_eq("stop_no_req", 32'(MC_req), 32'd0);

        // pc wrap at the top of the address space.
        do_clr(32'hFFFF_FFFC);
        tick();
        IQ_full = 1'b0;
        addr_q.push_back(32'hFFFF_FFFC);
        addr_q.push_back(32'h0);
        wait_pushes(2);
        IQ_full = 1'b1;
        repeat (3) tick();

`ifdef ICACHE_EN
        // Second pass over 0x0..0xC served from the cache without MC_req.
        IQ_full = 1'b0;
        do_reset();
        addr_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        wait_pushes(4);
        wait_addr(32'h10);
        do_clr(32'h0);
        for (int i = 0; i < 4; i++) exp_q.push_back({32'(i * 4), mc_word(32'(i * 4))});
        wait_pushes(4);
        IQ_full = 1'b1;
        repeat (3) begin
            tick();
            check_eq("cache_no_req", 32'(MC_req), 32'd0);
        end
`endif

        check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check_eq("addr_q_drained", 32'(addr_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
